// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: collects N serial beats into one parallel frame.
// Optional framing checks enabled by defining TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         din,
  input  logic                 din_vld,
  input  logic                 sof,
  output logic [N*W-1:0]       dout,
  output logic                 dout_vld,
  output logic [$clog2(N)-1:0] sel,
  output logic                 locked,
  output logic                 sync_err
);

  // state | meaning
  // HUNT  | waiting for a beat with sof to align on channel 0
  // LOCK  | aligned; beats are stored positionally by sel
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam int SW = $clog2(N);

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [W-1:0]   shadow_q [N-1];
  logic [W-1:0]   shadow_d [N-1];
  logic [N*W-1:0] dout_q, dout_d;
  logic           dout_vld_q, dout_vld_d;
  logic           sync_err_q, sync_err_d;
  logic           take_beat;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    sync_err_d = 1'b0;
    take_beat  = 1'b0;

    if (din_vld) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_d[0] = din;
            sel_d       = SW'(1);
            state_d     = LOCK;
          end
        end
        LOCK: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          if (sof && (sel_q != '0)) begin
            // resync on the early sof: restart the frame from this beat
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            sel_d       = SW'(1);
          end else if (!sof && (sel_q == '0)) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            take_beat = 1'b1;
          end
`else
          take_beat = 1'b1;
`endif
        end
        default: state_d = HUNT;
      endcase
    end

    if (take_beat) begin
      if (sel_q == SW'(N-1)) begin
        for (int k = 0; k < N-1; k++) begin
          dout_d[k*W +: W] = shadow_q[k];
        end
        dout_d[(N-1)*W +: W] = din;
        dout_vld_d           = 1'b1;
        sel_d                = '0;
      end else begin
        for (int k = 0; k < N-1; k++) begin
          if (sel_q == SW'(k)) shadow_d[k] = din;
        end
        sel_d = sel_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      sel_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sync_err_q <= 1'b0;
      for (int k = 0; k < N-1; k++) shadow_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sync_err_q <= sync_err_d;
      for (int k = 0; k < N-1; k++) shadow_q[k] <= shadow_d[k];
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sel      = sel_q;
  assign locked   = (state_q == LOCK);
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N=4, W=8); expected frames queued at stimulus,
// checked by a monitor on every dout_vld strobe.
module tb_tdm_demux;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_vld;
  logic           sof;
  logic [N*W-1:0] dout;
  logic           dout_vld;
  logic [1:0]     sel;
  logic           locked;
  logic           sync_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit done = 1'b0;

  tdm_demux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
    .dout(dout), .dout_vld(dout_vld), .sel(sel), .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every strobe must match the oldest queued frame
  always @(negedge clk) begin
    if (!done && dout_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got dout=0x%0h with no frame expected", dout);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL frame: got dout=0x%0h expected 0x%0h", dout, e);
        end
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic s);
    din = d; sof = s; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0; sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_vld = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    din = '0; din_vld = 1'b0; sof = 1'b0; rst = 1'b0;
    do_reset();
    chk("rst_dout", dout, 32'h0);
    chk("rst_dout_vld", {31'b0, dout_vld}, 32'h0);
    chk("rst_sel", {30'b0, sel}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);
    chk("rst_sync_err", {31'b0, sync_err}, 32'h0);

    // basic frame, first cycle after reset accepts sof
    exp_q.push_back(32'h44332211);
    beat(8'h11, 1'b1);
    chk("first_sof_locked", {31'b0, locked}, 32'h1);
    chk("first_sof_sel", {30'b0, sel}, 32'h1);
    beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    chk("f1_vld", {31'b0, dout_vld}, 32'h1);
    chk("f1_sel", {30'b0, sel}, 32'h0);
    chk("f1_locked", {31'b0, locked}, 32'h1);
    idle(1);
    chk("f1_vld_one_cycle", {31'b0, dout_vld}, 32'h0);
    chk("f1_hold", dout, 32'h44332211);

    // hunt drops beats without sof
    do_reset();
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
    chk("hunt_locked", {31'b0, locked}, 32'h0);
    chk("hunt_sel", {30'b0, sel}, 32'h0);
    beat(8'hA0, 1'b1);
    chk("hunt_lock_rise", {31'b0, locked}, 32'h1);
    exp_q.push_back(32'hA3A2A1A0);
    beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0);

    // back-to-back frame then a stalled frame
    exp_q.push_back(32'hB3B2B1B0);
    beat(8'hB0, 1'b1); beat(8'hB1, 1'b0); beat(8'hB2, 1'b0); beat(8'hB3, 1'b0);
    beat(8'hC0, 1'b1); beat(8'hC1, 1'b0);
    idle(1);
    chk("stall_sel_a", {30'b0, sel}, 32'h2);
    chk("stall_dout_a", dout, 32'hB3B2B1B0);
    idle(1);
    chk("stall_sel_b", {30'b0, sel}, 32'h2);
    chk("stall_vld", {31'b0, dout_vld}, 32'h0);
    exp_q.push_back(32'hC3C2C1C0);
    beat(8'hC2, 1'b0);
    chk("stall_no_early_vld", {31'b0, dout_vld}, 32'h0);
    beat(8'hC3, 1'b0);
    chk("stall_vld_after_last", {31'b0, dout_vld}, 32'h1);

    // reset mid-frame overrides a valid beat
    beat(8'h11, 1'b1); beat(8'h22, 1'b0);
    rst = 1'b1; din = 8'h33; din_vld = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_vld = 1'b0;
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_locked", {31'b0, locked}, 32'h0);
    chk("midrst_sel", {30'b0, sel}, 32'h0);
    idle(2);
    chk("midrst_no_vld", {31'b0, dout_vld}, 32'h0);
    exp_q.push_back(32'h88776655);
    beat(8'h55, 1'b1); beat(8'h66, 1'b0); beat(8'h77, 1'b0); beat(8'h88, 1'b0);

    // sof on the third beat
    beat(8'hD0, 1'b1); beat(8'hD1, 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    beat(8'hE0, 1'b1);
    chk("early_sof_err", {31'b0, sync_err}, 32'h1);
    chk("early_sof_sel", {30'b0, sel}, 32'h1);
    chk("early_sof_locked", {31'b0, locked}, 32'h1);
    exp_q.push_back(32'hE3E2E1E0);
    beat(8'hE1, 1'b0);
    chk("early_sof_err_pulse", {31'b0, sync_err}, 32'h0);
    beat(8'hE2, 1'b0); beat(8'hE3, 1'b0);
`else
    exp_q.push_back(32'hE1E0D1D0);
    beat(8'hE0, 1'b1);
    chk("early_sof_no_err", {31'b0, sync_err}, 32'h0);
    chk("early_sof_sel", {30'b0, sel}, 32'h3);
    beat(8'hE1, 1'b0); beat(8'hE2, 1'b0); beat(8'hE3, 1'b0);
    chk("early_sof_pos_sel", {30'b0, sel}, 32'h2);
`endif

    // missing sof at sel=0
    do_reset();
    exp_q.push_back(32'hF3F2F1F0);
    beat(8'hF0, 1'b1); beat(8'hF1, 1'b0); beat(8'hF2, 1'b0); beat(8'hF3, 1'b0);
    beat(8'h90, 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("miss_sof_err", {31'b0, sync_err}, 32'h1);
    chk("miss_sof_unlock", {31'b0, locked}, 32'h0);
    beat(8'h91, 1'b0); beat(8'h92, 1'b0); beat(8'h93, 1'b0);
    chk("miss_sof_hunt_sel", {30'b0, sel}, 32'h0);
`else
    chk("miss_sof_no_err", {31'b0, sync_err}, 32'h0);
    chk("miss_sof_locked", {31'b0, locked}, 32'h1);
    exp_q.push_back(32'h93929190);
    beat(8'h91, 1'b0); beat(8'h92, 1'b0); beat(8'h93, 1'b0);
`endif
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
